// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the slave mux.
package ahb_lite_pkg;

  localparam int unsigned W_HRESP = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [W_HRESP-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [W_HRESP-1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // NONSEQ and SEQ carry data; IDLE and BUSY do not.
  function automatic logic htrans_active(logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mux_if.sv
// Bus bundle between the single AHB-Lite master, the slave mux and N_SLAVE slaves.
// Modports: mux (the decoder/multiplexer), master (bus master), slave (slave side).
interface ahb_lite_slave_mux_if
  import ahb_lite_pkg::*;
#(
  parameter int unsigned N_SLAVE = 4,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_BURST = 3
);

  // Master side
  logic [W_ADDR-1:0]          ma_HADDR;
  logic [1:0]                 ma_HTRANS;
  logic                       ma_HWRITE;
  logic [2:0]                 ma_HSIZE;
  logic [W_BURST-1:0]         ma_HBURST;
  logic [W_DATA-1:0]          ma_HWDATA;
  logic                       out_ma_HREADY;
  logic [W_HRESP-1:0]         out_ma_HRESP;
  logic [W_DATA-1:0]          out_ma_HRDATA;

  // Slave side
  logic [N_SLAVE-1:0]         out_sl_HSEL;
  logic [W_ADDR-1:0]          out_sl_HADDR;
  logic [1:0]                 out_sl_HTRANS;
  logic                       out_sl_HWRITE;
  logic [2:0]                 out_sl_HSIZE;
  logic [W_BURST-1:0]         out_sl_HBURST;
  logic [W_DATA-1:0]          out_sl_HWDATA;
  logic                       out_sl_HREADY;
  logic [N_SLAVE-1:0]         sl_HREADY;
  logic [N_SLAVE*W_HRESP-1:0] sl_HRESP;
  logic [N_SLAVE*W_DATA-1:0]  sl_HRDATA;

  logic                       int_timeout;

  modport mux (
    input  ma_HADDR, ma_HTRANS, ma_HWRITE, ma_HSIZE, ma_HBURST, ma_HWDATA,
    input  sl_HREADY, sl_HRESP, sl_HRDATA,
    output out_ma_HREADY, out_ma_HRESP, out_ma_HRDATA,
    output out_sl_HSEL, out_sl_HADDR, out_sl_HTRANS, out_sl_HWRITE, out_sl_HSIZE,
    output out_sl_HBURST, out_sl_HWDATA, out_sl_HREADY,
    output int_timeout
  );

  modport master (
    output ma_HADDR, ma_HTRANS, ma_HWRITE, ma_HSIZE, ma_HBURST, ma_HWDATA,
    input  out_ma_HREADY, out_ma_HRESP, out_ma_HRDATA, int_timeout
  );

  modport slave (
    input  out_sl_HSEL, out_sl_HADDR, out_sl_HTRANS, out_sl_HWRITE, out_sl_HSIZE,
    input  out_sl_HBURST, out_sl_HWDATA, out_sl_HREADY,
    output sl_HREADY, sl_HRESP, sl_HRDATA
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR.
// With AHB_SLAVE_TIMEOUT_EN defined it also bounds slave wait states: after
// TIMEOUT_CYC consecutive stalled cycles it forces the same two-cycle ERROR and
// pulses int_timeout during the first ERROR cycle.
module ahb_default_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               accept,       // HREADY seen by the master this cycle
  input  logic               active_miss,  // active transfer with no slave hit
  input  logic               stall,        // selected slave holding HREADY low
  output logic               ds_hready,
  output logic [W_HRESP-1:0] ds_hresp,
  output logic               ds_busy,      // response currently owned by the FSM
  output logic               tmo_fire,     // clear the data-phase select
  output logic               int_timeout
);

  ds_state_e state_q, state_d;

`ifdef AHB_SLAVE_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] tmo_cnt_q;
  logic       tmo_pulse_q;

  // The stall being counted now is the TIMEOUT_CYC-th in a row.
  assign tmo_fire = (state_q == DS_IDLE) && stall && (tmo_cnt_q == TmoLast);

  // Count consecutive stalled data-phase cycles; any accepted transfer restarts it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_cnt_q <= '0;
    end else if (accept || tmo_fire) begin
      tmo_cnt_q <= '0;
    end else if (stall) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  // Pulse lines up with the DS_ERR1 cycle that the firing edge enters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_pulse_q <= tmo_fire;
    end
  end

  assign int_timeout = tmo_pulse_q;
`else
  logic unused_tmo;
  assign unused_tmo  = stall ^ (TIMEOUT_CYC == 0);
  assign tmo_fire    = 1'b0;
  assign int_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and response outputs
  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (tmo_fire || (accept && active_miss)) begin
          state_d = DS_ERR1;
        end
      end
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp = HRESP_ERROR;
        state_d  = (accept && active_miss) ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  assign ds_busy = (state_q != DS_IDLE);

endmodule

// File: rtl/ahb_lite_slave_mux.sv
// AHB-Lite address decoder and response multiplexer for one master and N_SLAVE
// slaves. Unmapped accesses are answered by ahb_default_slave. Optional wait-state
// timeout is enabled with the AHB_SLAVE_TIMEOUT_EN macro.
module ahb_lite_slave_mux
  import ahb_lite_pkg::*;
#(
  parameter int unsigned                N_SLAVE     = 4,
  parameter int unsigned                W_ADDR      = 32,
  parameter int unsigned                W_DATA      = 32,
  parameter int unsigned                W_BURST     = 3,
  parameter logic [N_SLAVE*W_ADDR-1:0]  ADDR_BASE   = {N_SLAVE{32'h0}},
  parameter logic [N_SLAVE*W_ADDR-1:0]  ADDR_MASK   = {N_SLAVE{32'hFFFF_F000}},
  parameter int unsigned                TIMEOUT_CYC = 16
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_lite_slave_mux_if.mux bus
);

  logic [N_SLAVE-1:0] hit;
  logic [N_SLAVE-1:0] hsel;
  logic               miss;
  logic               active;

  logic [N_SLAVE-1:0] dp_slv_q;
  logic               dp_def_q;

  logic               hready;
  logic [W_HRESP-1:0] hresp;
  logic [W_DATA-1:0]  hrdata;

  logic               stall;
  logic               ds_hready;
  logic [W_HRESP-1:0] ds_hresp;
  logic               ds_busy;
  logic               tmo_fire;

  // Address decode against each slave's masked base
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_SLAVE; i++) begin
      hit[i] = ((bus.ma_HADDR & ADDR_MASK[i*W_ADDR +: W_ADDR]) ==
                (ADDR_BASE[i*W_ADDR +: W_ADDR] & ADDR_MASK[i*W_ADDR +: W_ADDR]));
    end
  end

  // Lowest index wins on overlapping maps: scan downwards so it is written last
  always_comb begin
    hsel = '0;
    for (int i = int'(N_SLAVE) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign miss   = ~|hit;
  assign active = htrans_active(bus.ma_HTRANS);

  // Data-phase owner advances only when the master sees HREADY
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_slv_q <= '0;
      dp_def_q <= 1'b0;
    end else if (tmo_fire) begin
      dp_slv_q <= '0;
      dp_def_q <= 1'b0;
    end else if (hready) begin
      dp_slv_q <= hsel;
      dp_def_q <= miss;
    end
  end

  assign stall = |(dp_slv_q & ~bus.sl_HREADY);

  ahb_default_slave #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_default_slave (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .accept      (hready),
    .active_miss (active && miss),
    .stall       (stall),
    .ds_hready   (ds_hready),
    .ds_hresp    (ds_hresp),
    .ds_busy     (ds_busy),
    .tmo_fire    (tmo_fire),
    .int_timeout (bus.int_timeout)
  );

  // Response mux: default slave, selected slave pass-through, else idle OKAY
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    if (dp_def_q || ds_busy) begin
      hready = ds_hready;
      hresp  = ds_hresp;
    end else begin
      for (int unsigned i = 0; i < N_SLAVE; i++) begin
        if (dp_slv_q[i]) begin
          hready = bus.sl_HREADY[i];
          hresp  = bus.sl_HRESP[i*W_HRESP +: W_HRESP];
          hrdata = bus.sl_HRDATA[i*W_DATA +: W_DATA];
        end
      end
    end
  end

  assign bus.out_ma_HREADY = hready;
  assign bus.out_ma_HRESP  = hresp;
  assign bus.out_ma_HRDATA = hrdata;

  assign bus.out_sl_HSEL   = hsel;
  assign bus.out_sl_HADDR  = bus.ma_HADDR;
  assign bus.out_sl_HTRANS = bus.ma_HTRANS;
  assign bus.out_sl_HWRITE = bus.ma_HWRITE;
  assign bus.out_sl_HSIZE  = bus.ma_HSIZE;
  assign bus.out_sl_HBURST = W_BURST'(bus.ma_HBURST);
  assign bus.out_sl_HWDATA = bus.ma_HWDATA;
  assign bus.out_sl_HREADY = hready;

endmodule

// File: tb/tb_ahb_lite_slave_mux.sv
// Self-checking bench for ahb_lite_slave_mux: behavioural slaves, a pipelined
// master driver and an in-order response scoreboard.
module tb_ahb_lite_slave_mux;
  import ahb_lite_pkg::*;

  localparam int unsigned NS = 4;
  localparam logic [NS*32-1:0] BASE = {32'h4000_3000, 32'h4000_2000, 32'h4000_1000,
                                       32'h4000_0000};
  localparam logic [NS*32-1:0] MASK = {NS{32'hFFFF_F000}};
  localparam logic [63:0] OVL_BASE = {32'h5000_0000, 32'h5000_0000};
  localparam logic [63:0] OVL_MASK = {2{32'hFFFF_F000}};

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        chk_data;
  } xfer_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb_lite_slave_mux_if #(.N_SLAVE(NS), .W_ADDR(32), .W_DATA(32), .W_BURST(3)) bus ();
  ahb_lite_slave_mux_if #(.N_SLAVE(2), .W_ADDR(32), .W_DATA(32), .W_BURST(3)) ovl_bus ();

  ahb_lite_slave_mux #(
    .N_SLAVE(NS), .W_ADDR(32), .W_DATA(32), .W_BURST(3),
    .ADDR_BASE(BASE), .ADDR_MASK(MASK), .TIMEOUT_CYC(16)
  ) u_dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  ahb_lite_slave_mux #(
    .N_SLAVE(2), .W_ADDR(32), .W_DATA(32), .W_BURST(3),
    .ADDR_BASE(OVL_BASE), .ADDR_MASK(OVL_MASK), .TIMEOUT_CYC(16)
  ) u_ovl (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (ovl_bus)
  );

  // Overlap instance only exercises the combinational decode
  assign ovl_bus.ma_HADDR  = bus.ma_HADDR;
  assign ovl_bus.ma_HTRANS = HTRANS_IDLE;
  assign ovl_bus.ma_HWRITE = 1'b0;
  assign ovl_bus.ma_HSIZE  = 3'b010;
  assign ovl_bus.ma_HBURST = 3'b000;
  assign ovl_bus.ma_HWDATA = 32'h0;
  assign ovl_bus.sl_HREADY = '1;
  assign ovl_bus.sl_HRESP  = '0;
  assign ovl_bus.sl_HRDATA = '0;

  // Behavioural slaves: configurable wait states, read data, or endless stall
  int unsigned cfg_wait [NS];
  logic [31:0] cfg_rdata [NS];
  logic [NS-1:0] cfg_hang;
  logic [NS-1:0] sl_dp, sl_wr, sl_rdy;
  int unsigned sl_wait [NS];
  logic [31:0] sl_wdata [NS];

  always_comb begin
    sl_rdy = '0;
    bus.sl_HREADY = '0;
    bus.sl_HRESP  = '0;
    bus.sl_HRDATA = '0;
    for (int i = 0; i < NS; i++) begin
      sl_rdy[i] = !sl_dp[i] || (sl_wait[i] == 0 && !cfg_hang[i]);
      bus.sl_HREADY[i] = sl_rdy[i];
      bus.sl_HRDATA[i*32 +: 32] = (sl_dp[i] && !sl_wr[i]) ? cfg_rdata[i] : 32'h0;
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    for (int i = 0; i < NS; i++) begin
      if (!HRESETn) begin
        sl_dp[i]    <= 1'b0;
        sl_wr[i]    <= 1'b0;
        sl_wait[i]  <= 0;
        sl_wdata[i] <= 32'h0;
      end else begin
        if (sl_dp[i] && sl_wait[i] != 0) sl_wait[i] <= sl_wait[i] - 1;
        if (sl_dp[i] && sl_rdy[i] && sl_wr[i]) sl_wdata[i] <= bus.out_sl_HWDATA;
        if (bus.out_sl_HREADY) begin
          sl_dp[i]   <= bus.out_sl_HSEL[i] && bus.out_sl_HTRANS[1];
          sl_wr[i]   <= bus.out_sl_HWRITE;
          sl_wait[i] <= cfg_wait[i];
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  xfer_t stim_q[$];
  xfer_t exp_q[$];
  int done_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive_idle();
    bus.ma_HADDR  = 32'h0;
    bus.ma_HTRANS = HTRANS_IDLE;
    bus.ma_HWRITE = 1'b0;
    bus.ma_HSIZE  = 3'b010;
    bus.ma_HBURST = 3'b000;
    bus.ma_HWDATA = 32'h0;
  endtask

  task automatic push(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [1:0] resp, input logic [31:0] rdata, input logic chk);
    xfer_t x;
    x.addr = addr; x.wr = wr; x.wdata = wdata; x.resp = resp; x.rdata = rdata;
    x.chk_data = chk;
    stim_q.push_back(x);
  endtask

  // Pipelined master: call at posedge+1; drains stim_q, scoring each data phase
  task automatic run_stim(input int budget);
    xfer_t ap, dp, e;
    logic ap_v, dp_v, rdy;
    int cyc;
    ap_v = 1'b0; dp_v = 1'b0; cyc = 0;
    done_cyc.delete();
    if (stim_q.size() != 0) begin
      ap = stim_q.pop_front(); ap_v = 1'b1; exp_q.push_back(ap);
    end
    while ((ap_v || dp_v) && cyc < budget) begin
      bus.ma_HADDR  = ap_v ? ap.addr : 32'h0;
      bus.ma_HTRANS = ap_v ? HTRANS_NONSEQ : HTRANS_IDLE;
      bus.ma_HWRITE = ap_v && ap.wr;
      bus.ma_HWDATA = (dp_v && dp.wr) ? dp.wdata : 32'h0;
      @(negedge HCLK);
      rdy = bus.out_ma_HREADY;
      if (dp_v && rdy) begin
        e = exp_q.pop_front();
        check("resp", 32'(bus.out_ma_HRESP), 32'(e.resp));
        if (e.chk_data) check("rdata", bus.out_ma_HRDATA, e.rdata);
        done_cyc.push_back(cyc);
      end
      @(posedge HCLK); #1;
      cyc++;
      if (rdy) begin
        dp_v = ap_v; dp = ap; ap_v = 1'b0;
        if (stim_q.size() != 0) begin
          ap = stim_q.pop_front(); ap_v = 1'b1; exp_q.push_back(ap);
        end
      end
    end
    check("stim_drained", 32'(ap_v || dp_v), 32'd0);
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      cfg_wait[i] = 0; cfg_rdata[i] = 32'h0;
    end
    cfg_hang = '0;
    drive_idle();
    bus.ma_HADDR = 32'h9000_0000;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hready", 32'(bus.out_ma_HREADY), 32'd1);
    check("rst_hresp", 32'(bus.out_ma_HRESP), 32'd0);
    check("rst_hrdata", bus.out_ma_HRDATA, 32'h0);
    check("rst_hsel", 32'(bus.out_sl_HSEL), 32'h0);
    check("rst_tmo", 32'(bus.int_timeout), 32'd0);
    HRESETn = 1'b1;

    // Decode, HSEL independent of HTRANS
    @(posedge HCLK); #1; bus.ma_HADDR = 32'h4000_2004; @(negedge HCLK);
    check("hsel_s2", 32'(bus.out_sl_HSEL), 32'b0100);
    @(posedge HCLK); #1; bus.ma_HADDR = 32'h4000_0FFC; @(negedge HCLK);
    check("hsel_s0", 32'(bus.out_sl_HSEL), 32'b0001);
    @(posedge HCLK); #1; bus.ma_HADDR = 32'h4000_3000; @(negedge HCLK);
    check("hsel_s3", 32'(bus.out_sl_HSEL), 32'b1000);
    @(posedge HCLK); #1; bus.ma_HADDR = 32'h5000_0010; @(negedge HCLK);
    check("hsel_none", 32'(bus.out_sl_HSEL), 32'b0000);
    check("hsel_ovl", 32'(ovl_bus.out_sl_HSEL), 32'b01);

    // Write to slave 2
    @(posedge HCLK); #1;
    push(32'h4000_2004, 1'b1, 32'hDEAD_BEEF, HRESP_OKAY, 32'h0, 1'b1);
    run_stim(20);
    check("s2_wdata", sl_wdata[2], 32'hDEAD_BEEF);

    // Unmapped read: one stalled ERROR cycle then a ready ERROR cycle
    @(posedge HCLK); #1;
    bus.ma_HADDR = 32'h9000_0000; bus.ma_HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    check("miss_hsel", 32'(bus.out_sl_HSEL), 32'h0);
    @(posedge HCLK); #1; drive_idle(); @(negedge HCLK);
    check("err1_hready", 32'(bus.out_ma_HREADY), 32'd0);
    check("err1_hresp", 32'(bus.out_ma_HRESP), 32'(HRESP_ERROR));
    @(posedge HCLK); #1; @(negedge HCLK);
    check("err2_hready", 32'(bus.out_ma_HREADY), 32'd1);
    check("err2_hresp", 32'(bus.out_ma_HRESP), 32'(HRESP_ERROR));
    @(posedge HCLK); #1; @(negedge HCLK);
    check("post_err_hresp", 32'(bus.out_ma_HRESP), 32'(HRESP_OKAY));

    // Pipelined reads: slave 0 with two wait states, then slave 1
    cfg_wait[0] = 2; cfg_rdata[0] = 32'h1111;
    cfg_wait[1] = 0; cfg_rdata[1] = 32'h2222;
    @(posedge HCLK); #1;
    push(32'h4000_0010, 1'b0, 32'h0, HRESP_OKAY, 32'h1111, 1'b1);
    push(32'h4000_1020, 1'b0, 32'h0, HRESP_OKAY, 32'h2222, 1'b1);
    run_stim(30);
    check("pipe_lat0", 32'(done_cyc[0]), 32'd3);
    check("pipe_lat1", 32'(done_cyc[1]), 32'd4);

    // Mixed stream: slave, miss, write behind the ERROR, slave
    cfg_wait[0] = 0; cfg_wait[3] = 1; cfg_rdata[3] = 32'h3333_3333;
    cfg_rdata[2] = 32'h2222_AAAA;
    @(posedge HCLK); #1;
    push(32'h4000_3008, 1'b0, 32'h0, HRESP_OKAY, 32'h3333_3333, 1'b1);
    push(32'h8000_0000, 1'b0, 32'h0, HRESP_ERROR, 32'h0, 1'b0);
    push(32'h4000_0040, 1'b1, 32'h0BAD_F00D, HRESP_OKAY, 32'h0, 1'b1);
    push(32'h4000_2100, 1'b0, 32'h0, HRESP_OKAY, 32'h2222_AAAA, 1'b1);
    run_stim(40);
    check("s0_wdata", sl_wdata[0], 32'h0BAD_F00D);
    check("mix_err_lat", 32'(done_cyc[1]), 32'd4);

`ifdef AHB_SLAVE_TIMEOUT_EN
    begin
      int cyc;
      logic seen;
      cfg_hang[3] = 1'b1;
      @(posedge HCLK); #1;
      bus.ma_HADDR = 32'h4000_3000; bus.ma_HTRANS = HTRANS_NONSEQ;
      @(posedge HCLK); #1; drive_idle();
      cyc = 1; seen = 1'b0;
      while (cyc < 40 && !seen) begin
        @(negedge HCLK);
        if (bus.int_timeout) seen = 1'b1;
        else begin @(posedge HCLK); #1; cyc++; end
      end
      check("tmo_cycle", 32'(cyc), 32'd17);
      check("tmo_err1_hready", 32'(bus.out_ma_HREADY), 32'd0);
      check("tmo_err1_hresp", 32'(bus.out_ma_HRESP), 32'(HRESP_ERROR));
      @(posedge HCLK); #1; @(negedge HCLK);
      check("tmo_err2_hready", 32'(bus.out_ma_HREADY), 32'd1);
      check("tmo_err2_hresp", 32'(bus.out_ma_HRESP), 32'(HRESP_ERROR));
      check("tmo_pulse_end", 32'(bus.int_timeout), 32'd0);
      cfg_hang[3] = 1'b0;
      @(posedge HCLK); #1;
      push(32'h4000_2010, 1'b0, 32'h0, HRESP_OKAY, 32'h2222_AAAA, 1'b1);
      run_stim(20);
    end
`endif

    // Asynchronous reset during a stalled data phase
    cfg_wait[0] = 5;
    @(posedge HCLK); #1;
    bus.ma_HADDR = 32'h4000_0000; bus.ma_HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1; drive_idle(); @(negedge HCLK);
    check("ar_stall", 32'(bus.out_ma_HREADY), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check("ar_hready", 32'(bus.out_ma_HREADY), 32'd1);
    check("ar_hresp", 32'(bus.out_ma_HRESP), 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_lite_slave_mux.md
Name: ahb_lite_slave_mux

Overview:
Parametrised AHB-Lite address decoder and response multiplexer for one master and N_SLAVE slaves.
It generalises the fixed two-slave ALU/multiplier hookup to an arbitrary slave count and address map.
It adds a built-in default slave that returns a two-cycle ERROR for unmapped accesses, and data-phase tracking so pipelined transfers to different slaves return correct responses.
It sits between the single RISC-V bus master and the peripheral slaves, and replaces the interconnect for single-master systems.

Parameters:
N_SLAVE, 4, number of mapped slaves (1..16)
W_ADDR, 32, address width
W_DATA, 32, data width
W_BURST, 3, HBURST width
ADDR_BASE, {N_SLAVE{32'h0}}, packed per-slave base addresses; slave i occupies bits [i*W_ADDR +: W_ADDR]
ADDR_MASK, {N_SLAVE{32'hFFFF_F000}}, packed per-slave decode masks, same packing
TIMEOUT_CYC, 16, wait-state limit; used only with the optional feature

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
ma_HADDR  in  W_ADDR  master address
ma_HTRANS  in  2  master transfer type
ma_HWRITE  in  1  master write flag
ma_HSIZE  in  3  master size
ma_HBURST  in  W_BURST  master burst
ma_HWDATA  in  W_DATA  master write data
out_ma_HREADY  out  1  muxed ready to master
out_ma_HRESP  out  2  muxed response to master
out_ma_HRDATA  out  W_DATA  muxed read data to master
out_sl_HSEL  out  N_SLAVE  one-hot slave select
out_sl_HADDR / HTRANS / HWRITE / HSIZE / HBURST / HWDATA  out  as master  broadcast to all slaves
out_sl_HREADY  out  1  broadcast HREADYIN (equals out_ma_HREADY)
sl_HREADY  in  N_SLAVE  per-slave HREADYOUT
sl_HRESP  in  N_SLAVE*2  per-slave response
sl_HRDATA  in  N_SLAVE*W_DATA  per-slave read data
int_timeout  out  1  one-cycle pulse when a timeout fires (tied 0 without the feature)

Behaviour:
- Decode (combinational): hit[i] = ((ma_HADDR & MASK_i) == (BASE_i & MASK_i)). On overlapping maps the lowest index wins. out_sl_HSEL = one-hot of the winner, independent of HTRANS.
- miss = no hit. Active = HTRANS is NONSEQ (2'b10) or SEQ (2'b11).
- Data-phase register dp_sel (one-hot plus a DEF bit) loads the address-phase decode only when out_ma_HREADY = 1; otherwise it holds.
- Reset: dp_sel = none; default-slave FSM = DS_IDLE.
- Response when dp_sel = none, or when DEF is selected with an inactive transfer: HREADY = 1, HRESP = OKAY (2'b00), HRDATA = 0.
- Response when dp_sel = slave i: pass sl_HREADY[i], sl_HRESP[i] and sl_HRDATA[i] straight through (zero added latency).
- Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE -> DS_ERR1 when an active miss is accepted (out_ma_HREADY = 1).
  - DS_ERR1 outputs HREADY = 0, HRESP = ERROR (2'b01); next state DS_ERR2.
  - DS_ERR2 outputs HREADY = 1, HRESP = ERROR.
  - From DS_ERR2: go to DS_ERR1 if another active miss is accepted in the same cycle, else DS_IDLE.
- A new address phase presented during DS_ERR1 is not accepted. The master is stalled and the address is sampled at DS_ERR2.
- Back-to-back transfers: slave A data phase and slave B address phase overlap. HSEL to B is asserted immediately; dp_sel switches to B only on the cycle HREADY goes high.
- Asynchronous reset mid-transfer: dp_sel and the FSM clear immediately; outputs return to the idle response above.

Optional Feature:
Macro AHB_SLAVE_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter counts consecutive cycles with dp_sel = slave i and sl_HREADY[i] = 0.
  - When the count reaches TIMEOUT_CYC, the mux forces DS_ERR1 then DS_ERR2 (two-cycle ERROR to the master) and pulses int_timeout in the DS_ERR1 cycle.
  - dp_sel is then cleared to none; the stalled slave's later response is ignored.
  - The counter resets on any accepted transfer and on reset.
- Disabled: no counter, int_timeout = 0, and slave stalls are unbounded.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ
  - HRESP encodings OKAY/ERROR
  - default-slave state enum (2 bits)
  - W_HRESP = 2
- One sub-module, ahb_default_slave, contains the DS FSM and the optional timeout counter. The decoder and multiplexer stay in the top module.

Test Plan:
- Reset held for 3 cycles -> out_ma_HREADY = 1, HRESP = 0, HRDATA = 0, out_sl_HSEL = 0.
- N_SLAVE = 4, BASE2 = 0x4000_2000: NONSEQ write to 0x4000_2004 with data 0xDEAD_BEEF -> HSEL = 4'b0100; HWDATA is broadcast the next cycle; response is slave 2's OKAY.
- NONSEQ read to an unmapped 0x9000_0000 -> HREADY low with ERROR for 1 cycle, then high with ERROR; no HSEL bit hits.
- Pipelined read to slave 0 (2 wait states, data 0x1111) followed by read to slave 1 (data 0x2222) -> master sees 0x1111 after 3 cycles, then 0x2222; dp_sel switches only on HREADY.
- Overlapping BASE0 = BASE1 -> slave 0 selected.
- With AHB_SLAVE_TIMEOUT_EN and TIMEOUT_CYC = 16: slave 3 holds HREADY low forever -> at the 16th stall cycle int_timeout pulses and a two-cycle ERROR follows; the next transfer proceeds normally.
